// File: rtl/xnur_serial_compare_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// xnur_serial_compare_ctrl_pkg
// Shared definitions for the serial XNOR compare controller:
//   - FSM state encodings (IDLE / SHIFT / DRAIN)
//   - width helpers for the match counter and the bit index
// No ports (package).
// ---------------------------------------------------------------------------
package xnur_serial_compare_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Bits needed to hold a match count in the range 0..w.
   function automatic int cw_of(input int w);
      return $clog2(w + 1);
   endfunction

   // Bits needed to hold a bit index in the range 0..w-1.
   function automatic int iw_of(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/xnur_serial_compare_ctrl_hold_stage.sv
// ---------------------------------------------------------------------------
// xnur_hold_stage
// Single-bit registered hold/clear stage followed by an XNOR.
// On each edge a 1/1 pair clears both hold registers; any other pair is
// loaded. Because 0 XNOR 0 = 1, a cleared 1/1 pair still reports a match.
// Ports:
//   clk  in  1  clock
//   rst  in  1  synchronous active-high reset (clears the hold registers)
//   a    in  1  first operand bit
//   b    in  1  second operand bit
//   y    out 1  hold_a XNOR hold_b (one cycle after a/b are presented)
// ---------------------------------------------------------------------------
module xnur_hold_stage (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   output logic y
);

   logic hold_a_r;
   logic hold_b_r;

   // Hold registers: clear on reset or on a both-ones pair, otherwise load.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_a_r <= 1'b0;
         hold_b_r <= 1'b0;
      end else if (a && b) begin
         hold_a_r <= 1'b0;
         hold_b_r <= 1'b0;
      end else begin
         hold_a_r <= a;
         hold_b_r <= b;
      end
   end

   assign y = ~(hold_a_r ^ hold_b_r);

endmodule

// File: rtl/xnur_serial_compare_ctrl.sv
// ---------------------------------------------------------------------------
// xnur_serial_compare_ctrl
// Compares two W-bit words one bit pair per clock through the shared
// xnur_hold_stage and accumulates the per-bit equality results.
// Ports:
//   clk          in  1   clock
//   rst          in  1   synchronous active-high reset
//   start        in  1   request a comparison (sampled only in IDLE)
//   word_a       in  W   first operand, latched on accepted start
//   word_b       in  W   second operand, latched on accepted start
//   busy         out 1   comparison in progress
//   done         out 1   one-cycle pulse, results valid from this cycle on
//   match_count  out CW  number of equal bit positions
//   equal        out 1   match_count == W
//   first_diff   out IW  original index of the first compared mismatch
//   diff_valid   out 1   at least one mismatch found
// ---------------------------------------------------------------------------
module xnur_serial_compare_ctrl
   import xnur_serial_compare_ctrl_pkg::*;
#(
   parameter int  W         = 8,
   parameter bit  MSB_FIRST = 1'b1,
   localparam int CW        = cw_of(W),
   localparam int IW        = iw_of(W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  word_a,
   input  logic [W-1:0]  word_b,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] match_count,
   output logic          equal,
   output logic [IW-1:0] first_diff,
   output logic          diff_valid
);

   logic [1:0]    state_r;
   logic [W-1:0]  sh_a_r;
   logic [W-1:0]  sh_b_r;
   logic [IW-1:0] cnt_r;
   logic          acc_vld_r;   // stage output this cycle belongs to a compared bit
   logic [IW-1:0] idx_pipe_r;  // original index of the bit now in the stage
   logic          stage_a_s;
   logic          stage_b_s;
   logic          stage_y_s;
   logic [IW-1:0] bit_idx_s;
   logic [CW-1:0] mc_nxt_s;

   // Stage input selection, original bit index and next match count.
   always_comb begin
      stage_a_s = 1'b0;
      stage_b_s = 1'b0;
      bit_idx_s = MSB_FIRST ? (IW'(W - 1) - cnt_r) : cnt_r;
      if (state_r == ST_SHIFT) begin
         stage_a_s = MSB_FIRST ? sh_a_r[W-1] : sh_a_r[0];
         stage_b_s = MSB_FIRST ? sh_b_r[W-1] : sh_b_r[0];
      end else begin
         stage_a_s = 1'b0;
         stage_b_s = 1'b0;
      end
      mc_nxt_s = match_count + ((acc_vld_r && stage_y_s) ? CW'(1) : CW'(0));
   end

   xnur_hold_stage u_hold (
      .clk (clk),
      .rst (rst),
      .a   (stage_a_s),
      .b   (stage_b_s),
      .y   (stage_y_s)
   );

   // Sequencing FSM: operand latch, shifting, bit counter, busy/done/equal.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         sh_a_r  <= '0;
         sh_b_r  <= '0;
         cnt_r   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         equal   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sh_a_r  <= word_a;
                  sh_b_r  <= word_b;
                  cnt_r   <= '0;
                  busy    <= 1'b1;
                  equal   <= 1'b0;
                  state_r <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               done <= 1'b0;
               if (MSB_FIRST) begin
                  sh_a_r <= {sh_a_r[W-2:0], 1'b0};
                  sh_b_r <= {sh_b_r[W-2:0], 1'b0};
               end else begin
                  sh_a_r <= {1'b0, sh_a_r[W-1:1]};
                  sh_b_r <= {1'b0, sh_b_r[W-1:1]};
               end
               // Counter stops at W-1 so it never wraps.
               if (cnt_r == IW'(W - 1)) begin
                  state_r <= ST_DRAIN;
               end else begin
                  cnt_r <= cnt_r + IW'(1);
               end
            end
            ST_DRAIN: begin
               busy    <= 1'b0;
               done    <= 1'b1;
               equal   <= (mc_nxt_s == CW'(W));
               state_r <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // One-deep pipeline tagging the stage output with validity and bit index.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_vld_r  <= 1'b0;
         idx_pipe_r <= '0;
      end else begin
         acc_vld_r  <= (state_r == ST_SHIFT);
         idx_pipe_r <= bit_idx_s;
      end
   end

   // Accumulators: cleared on accepted start, updated from each valid y.
   always_ff @(posedge clk) begin
      if (rst) begin
         match_count <= '0;
         first_diff  <= '0;
         diff_valid  <= 1'b0;
      end else if ((state_r == ST_IDLE) && start) begin
         match_count <= '0;
         first_diff  <= '0;
         diff_valid  <= 1'b0;
      end else if (acc_vld_r) begin
         match_count <= mc_nxt_s;
         // Only the first compared mismatch is recorded.
         if (!stage_y_s && !diff_valid) begin
            first_diff <= idx_pipe_r;
            diff_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_xnur_serial_compare_ctrl.sv
// ---------------------------------------------------------------------------
// tb_xnur_serial_compare_ctrl
// Directed self-checking bench for xnur_serial_compare_ctrl (W=8, MSB first).
// ---------------------------------------------------------------------------
module tb_xnur_serial_compare_ctrl;

   localparam int W  = 8;
   localparam int CW = 4;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  word_a = '0;
   logic [W-1:0]  word_b = '0;
   logic          busy;
   logic          done;
   logic [CW-1:0] match_count;
   logic          equal;
   logic [IW-1:0] first_diff;
   logic          diff_valid;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   xnur_serial_compare_ctrl #(
      .W         (W),
      .MSB_FIRST (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .word_a      (word_a),
      .word_b      (word_b),
      .busy        (busy),
      .done        (done),
      .match_count (match_count),
      .equal       (equal),
      .first_diff  (first_diff),
      .diff_valid  (diff_valid)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive start for exactly one edge with the given words.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      word_a = a;
      word_b = b;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Count edges after the start edge until done is seen (bounded).
   task automatic wait_done(input int edges_in, output int edges);
      edges = edges_in;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (done) break;
      end
      if (!done) begin
         check_val("done_timeout", 32'(done), 32'd1);
      end
   endtask

   task automatic check_result(input string tag, input int edges,
                               input logic [CW-1:0] mc, input logic eq,
                               input logic [IW-1:0] fd, input logic dv);
      check_val({tag, "_latency"}, 32'(edges), 32'd9);
      check_val({tag, "_busy"},    32'(busy), 32'd0);
      check_val({tag, "_mc"},      32'(match_count), 32'(mc));
      check_val({tag, "_equal"},   32'(equal), 32'(eq));
      check_val({tag, "_dvalid"},  32'(diff_valid), 32'(dv));
      if (dv) begin
         check_val({tag, "_fdiff"}, 32'(first_diff), 32'(fd));
      end
   endtask

   // Count done pulses over n cycles.
   task automatic count_done(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
   endtask

   initial begin
      int edges;
      int pulses;

      // Reset for two cycles
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("rst_busy",  32'(busy), 32'd0);
      check_val("rst_done",  32'(done), 32'd0);
      check_val("rst_mc",    32'(match_count), 32'd0);
      check_val("rst_equal", 32'(equal), 32'd0);
      check_val("rst_fdiff", 32'(first_diff), 32'd0);
      check_val("rst_dv",    32'(diff_valid), 32'd0);

      // 1: A5 vs A5
      start_op(8'hA5, 8'hA5);
      check_val("t1_busy_run", 32'(busy), 32'd1);
      wait_done(0, edges);
      check_result("t1", edges, 4'd8, 1'b1, 3'd0, 1'b0);
      @(negedge clk);
      check_val("t1_done_pulse", 32'(done), 32'd0);
      check_val("t1_mc_hold",    32'(match_count), 32'd8);

      // 2: FF vs FF, every pair takes the clear path
      start_op(8'hFF, 8'hFF);
      wait_done(0, edges);
      check_result("t2", edges, 4'd8, 1'b1, 3'd0, 1'b0);

      // 3: FF vs 00, then F0 vs F1
      start_op(8'hFF, 8'h00);
      wait_done(0, edges);
      check_result("t3a", edges, 4'd0, 1'b0, 3'd7, 1'b1);
      start_op(8'hF0, 8'hF1);
      wait_done(0, edges);
      check_result("t3b", edges, 4'd7, 1'b0, 3'd0, 1'b1);

      // 4: second start while busy is ignored
      start_op(8'h0F, 8'h0F);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      word_a = 8'h00;
      word_b = 8'hFF;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(3, edges);
      check_result("t4", edges, 4'd8, 1'b1, 3'd0, 1'b0);
      count_done(12, pulses);
      check_val("t4_single_done", 32'(pulses), 32'd0);
      check_val("t4_idle_busy",   32'(busy), 32'd0);

      // 5: reset four edges into an operation
      start_op(8'hA5, 8'hA5);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_val("t5_mc_mid", 32'(match_count), 32'd3);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_val("t5_busy", 32'(busy), 32'd0);
      check_val("t5_done", 32'(done), 32'd0);
      check_val("t5_mc",   32'(match_count), 32'd0);
      check_val("t5_dv",   32'(diff_valid), 32'd0);
      count_done(12, pulses);
      check_val("t5_no_done", 32'(pulses), 32'd0);
      start_op(8'h5A, 8'h5B);
      wait_done(0, edges);
      check_result("t5_fresh", edges, 4'd7, 1'b0, 3'd0, 1'b1);

      // 6: start held high through the done cycle; word changes while busy ignored
      @(negedge clk);
      word_a = 8'h3C;
      word_b = 8'h3C;
      start  = 1'b1;
      @(posedge clk);
      #1;
      word_a = 8'h81;
      word_b = 8'h01;
      wait_done(0, edges);
      check_result("t6a", edges, 4'd8, 1'b1, 3'd0, 1'b0);
      @(posedge clk);
      #1 start = 1'b0;
      check_val("t6_busy_again", 32'(busy), 32'd1);
      wait_done(0, edges);
      check_result("t6b", edges, 4'd7, 1'b0, 3'd7, 1'b1);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
